lsu_mem_port: RTL

- Multicycle load/store unit; executes the memory access the decoder requests through its ld/store decode for RV32I load/store opcodes.
- Accepts one access per transaction from the core, drives a single-port data-memory bus with a req/ack handshake, and returns load data aligned and sign/zero-extended per func3.
- Sits between the execute stage (ALU result as address) and the data memory; holds the core stalled while busy.

---
 rtl/lsu_mem_port.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: multicycle RV32I load/store unit driving a single-port req/ack data memory.
// Optional macro LSU_MISALIGN_SPLIT_EN splits boundary-crossing accesses into two word accesses.
module lsu_mem_port #(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          is_store_i,
    input  logic [2:0]    func3_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [31:0]   rdata_o,
    output logic          err_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic [3:0]    mem_be_o,
    input  logic          mem_ack_i,
    input  logic [31:0]   mem_rdata_i
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StReq, StWait, StResp, StReq2, StWait2
    } state_e;

    state_e        state_q, state_d;
    logic          is_store_q, is_store_d;
    logic [2:0]    func3_q, func3_d;
    logic [1:0]    off_q, off_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wd_lo_q, wd_lo_d;
    logic [3:0]    be_lo_q, be_lo_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          illegal, misal;
    logic [3:0]    sz_mask;
    logic [31:0]   wd_rep;
    logic [31:0]   lane_w;
    logic          in_bus;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0]   wd_hi_q, wd_hi_d;
    logic [3:0]    be_hi_q, be_hi_d;
    logic          split_q, split_d;
    logic [31:0]   lo_word_q, lo_word_d;
    logic [7:0]    mask8;
    logic [31:0]   wd_sized;
    logic [63:0]   wd_sh;
    logic [63:0]   merged;
    logic          phase2;
`endif

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{w[7]}}, w[7:0]};
            3'b001:  r = {{16{w[15]}}, w[15:0]};
            3'b100:  r = {24'b0, w[7:0]};
            3'b101:  r = {16'b0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Request decode straight from the core inputs, used only when start is accepted.
    always_comb begin
        illegal = (func3_i == 3'b011) || (func3_i[2:1] == 2'b11) || (is_store_i && func3_i[2]);
        misal   = ((func3_i[1:0] == 2'b01) && addr_i[0])
               || ((func3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        case (func3_i[1:0])
            2'b00: begin
                sz_mask = 4'b0001;
                wd_rep  = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                sz_mask = 4'b0011;
                wd_rep  = {2{wdata_i[15:0]}};
            end
            default: begin
                sz_mask = 4'b1111;
                wd_rep  = wdata_i;
            end
        endcase
`ifdef LSU_MISALIGN_SPLIT_EN
        mask8 = {4'b0000, sz_mask} << addr_i[1:0];
        case (func3_i[1:0])
            2'b00:   wd_sized = {24'b0, wdata_i[7:0]};
            2'b01:   wd_sized = {16'b0, wdata_i[15:0]};
            default: wd_sized = wdata_i;
        endcase
        wd_sh = {32'b0, wd_sized} << {addr_i[1:0], 3'b000};
`endif
    end

    // Bring the addressed lane down to bit 0 before extension.
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        phase2 = (state_q == StReq2) || (state_q == StWait2);
        merged = phase2 ? {mem_rdata_i, lo_word_q} : {32'b0, mem_rdata_i};
        lane_w = 32'(merged >> {off_q, 3'b000});
`else
        lane_w = mem_rdata_i >> {off_q, 3'b000};
`endif
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        func3_d    = func3_q;
        off_d      = off_q;
        addr_d     = addr_q;
        wd_lo_d    = wd_lo_q;
        be_lo_d    = be_lo_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        wd_hi_d    = wd_hi_q;
        be_hi_d    = be_hi_q;
        split_d    = split_q;
        lo_word_d  = lo_word_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    is_store_d = is_store_i;
                    func3_d    = func3_i;
                    off_d      = addr_i[1:0];
                    addr_d     = {addr_i[AW-1:2], 2'b00};
                    cnt_d      = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    split_d    = (mask8[7:4] != 4'b0000);
                    be_lo_d    = mask8[3:0];
                    be_hi_d    = mask8[7:4];
                    wd_lo_d    = split_d ? wd_sh[31:0] : wd_rep;
                    wd_hi_d    = wd_sh[63:32];
                    err_d      = illegal;
                    state_d    = illegal ? StResp : StReq;
`else
                    be_lo_d    = sz_mask << addr_i[1:0];
                    wd_lo_d    = wd_rep;
                    err_d      = illegal || misal;
                    state_d    = (illegal || misal) ? StResp : StReq;
`endif
                end
            end
            StReq: state_d = StWait;
            StWait: begin
                if (mem_ack_i) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (split_q) begin
                        lo_word_d = mem_rdata_i;
                        cnt_d     = '0;
                        state_d   = StReq2;
                    end else begin
                        if (!is_store_q) rdata_d = load_ext(func3_q, lane_w);
                        state_d = StResp;
                    end
`else
                    if (!is_store_q) rdata_d = load_ext(func3_q, lane_w);
                    state_d = StResp;
`endif
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            StReq2: state_d = StWait2;
            StWait2: begin
                if (mem_ack_i) begin
                    if (!is_store_q) rdata_d = load_ext(func3_q, lane_w);
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            func3_q    <= '0;
            off_q      <= '0;
            addr_q     <= '0;
            wd_lo_q    <= '0;
            be_lo_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            cnt_q      <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            wd_hi_q    <= '0;
            be_hi_q    <= '0;
            split_q    <= 1'b0;
            lo_word_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            func3_q    <= func3_d;
            off_q      <= off_d;
            addr_q     <= addr_d;
            wd_lo_q    <= wd_lo_d;
            be_lo_q    <= be_lo_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            wd_hi_q    <= wd_hi_d;
            be_hi_q    <= be_hi_d;
            split_q    <= split_d;
            lo_word_q  <= lo_word_d;
`endif
        end
    end

    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        in_bus      = (state_q == StReq) || (state_q == StWait) || phase2;
        mem_addr_o  = phase2 ? addr_q + AW'(4) : addr_q;
        mem_wdata_o = phase2 ? wd_hi_q : wd_lo_q;
        mem_be_o    = in_bus ? (phase2 ? be_hi_q : be_lo_q) : 4'b0000;
`else
        in_bus      = (state_q == StReq) || (state_q == StWait);
        mem_addr_o  = addr_q;
        mem_wdata_o = wd_lo_q;
        mem_be_o    = in_bus ? be_lo_q : 4'b0000;
`endif
        mem_req_o = in_bus;
        mem_we_o  = in_bus && is_store_q;
        busy_o    = in_bus;
        done_o    = (state_q == StResp);
        err_o     = (state_q == StResp) && err_q;
        rdata_o   = rdata_q;
    end

endmodule
